// File: rtl/checkpoint_seq_monitor_pkg.sv
// Shared types and width helpers for the checkpoint sequence monitor.
package checkpoint_seq_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_RUN        = 3'd2,
    ST_PASS       = 3'd3,
    ST_FAIL       = 3'd4
  } ch_state_e;

  typedef enum logic [1:0] {
    SEL_EXP   = 2'd0,
    SEL_START = 2'd1,
    SEL_LEN   = 2'd2,
    SEL_MODE  = 2'd3
  } cfg_sel_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/checkpoint_seq_monitor_if.sv
// Probe, configuration and status bundle between a driver and the monitor.
interface checkpoint_seq_monitor_if
  import checkpoint_seq_monitor_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO_W = 24
);

  localparam int unsigned CH_W  = idx_w(CH);
  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned CFG_W = max_u(W, TMO_W + 1);

  logic [W-1:0]        probe;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_sel;
  logic [IDX_W-1:0]    cfg_idx;
  logic [CFG_W-1:0]    cfg_data;
  logic [CH-1:0]       arm;
  logic [CH-1:0]       hit;
  logic [CH-1:0]       pass;
  logic [CH-1:0]       fail;
  logic [CH*PTR_W-1:0] ptr;
  logic                all_done;

  modport master (
    output probe, cfg_we, cfg_ch, cfg_sel, cfg_idx, cfg_data, arm,
    input  hit, pass, fail, ptr, all_done
  );

  modport slave (
    input  probe, cfg_we, cfg_ch, cfg_sel, cfg_idx, cfg_data, arm,
    output hit, pass, fail, ptr, all_done
  );

endinterface

// File: rtl/checkpoint_channel.sv
// One monitor channel: waits for its start marker, then tracks the expected list
// with one-shot consumption per probe change, per-step timeout and optional strict mode.
module checkpoint_channel
  import checkpoint_seq_monitor_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned PTR_W = 4,
  parameter int unsigned TMO_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     probe,
  input  logic             arm,
  input  logic [W-1:0]     start,
  input  logic [W-1:0]     exp_val,
  input  logic [PTR_W-1:0] len,
  input  logic [TMO_W-1:0] limit,
  input  logic             strict,
  output logic             hit,
  output logic             pass,
  output logic             fail,
  output logic [PTR_W-1:0] ptr
);

  ch_state_e        state;
  logic [TMO_W-1:0] cnt;
  logic [W-1:0]     last_probe;
  logic             first;

  logic             changed;
  logic             match;
  logic             timeout;
  logic             violation;
  logic [PTR_W-1:0] ptr_inc;
  logic [TMO_W-1:0] cnt_inc;

  // A held value is consumed once; the first RUN cycle may match without a change.
  assign changed   = first || (probe != last_probe);
  assign match     = changed && (probe == exp_val);
  assign ptr_inc   = ptr + PTR_W'(1);
  assign cnt_inc   = cnt + TMO_W'(1);
  assign timeout   = (limit != '0) && (cnt_inc == limit);
  assign violation = strict && (probe != last_probe) && (probe != exp_val) && (probe != start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      last_probe <= '0;
      first      <= 1'b0;
      hit        <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      hit        <= 1'b0;
      first      <= 1'b0;
      last_probe <= probe;
      if (arm) begin
        state <= ST_WAIT_START;
        ptr   <= '0;
        cnt   <= '0;
        pass  <= 1'b0;
        fail  <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_START: begin
            if (probe == start) begin
              ptr <= '0;
              cnt <= '0;
              if (len == '0) begin
                state <= ST_PASS;
                pass  <= 1'b1;
              end else begin
                state <= ST_RUN;
                first <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            cnt <= cnt_inc;
            // Match beats timeout; >= keeps ptr saturated if len shrinks mid-run.
            if (match) begin
              hit <= 1'b1;
              ptr <= ptr_inc;
              cnt <= '0;
              if (ptr_inc >= len) begin
                state <= ST_PASS;
                pass  <= 1'b1;
              end
            end else if (timeout || violation) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Multi-channel checkpoint sequence monitor: config storage, CH channel FSMs
// and the registered all_done reduction over armed channels.
module checkpoint_seq_monitor
  import checkpoint_seq_monitor_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO_W = 24
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  checkpoint_seq_monitor_if.slave   bus
);

  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned CFG_W = max_u(W, TMO_W + 1);

  logic [W-1:0]                exp_mem   [CH][DEPTH];
  logic [W-1:0]                start_mem [CH];
  logic [CH-1:0][PTR_W-1:0]    len_mem;
  logic [CH-1:0][TMO_W-1:0]    limit_mem;
  logic [CH-1:0]               strict_mem;
  logic [CH-1:0]               armed;
  logic [CH-1:0]               hit;
  logic [CH-1:0]               pass;
  logic [CH-1:0]               fail;
  logic [PTR_W-1:0]            ptr_a     [CH];
  logic [CH*PTR_W-1:0]         ptr_flat;
  logic                        all_done;
  cfg_sel_e                    sel;
  logic [PTR_W-1:0]            len_wr;

  assign sel    = cfg_sel_e'(bus.cfg_sel);
  assign len_wr = (bus.cfg_data > CFG_W'(DEPTH)) ? PTR_W'(DEPTH) : bus.cfg_data[PTR_W-1:0];

  // Expected lists and start markers keep their contents across reset.
  always_ff @(posedge wb_clk_i) begin
    if (bus.cfg_we && (sel == SEL_EXP))   exp_mem[bus.cfg_ch][bus.cfg_idx] <= bus.cfg_data[W-1:0];
    if (bus.cfg_we && (sel == SEL_START)) start_mem[bus.cfg_ch]            <= bus.cfg_data[W-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      len_mem    <= '0;
      limit_mem  <= '0;
      strict_mem <= '0;
      armed      <= '0;
      all_done   <= 1'b0;
    end else begin
      armed    <= armed | bus.arm;
      all_done <= (armed != '0) && (((pass | fail) & armed) == armed);
      if (bus.cfg_we && (sel == SEL_LEN)) len_mem[bus.cfg_ch] <= len_wr;
      if (bus.cfg_we && (sel == SEL_MODE)) begin
        limit_mem[bus.cfg_ch]  <= bus.cfg_data[TMO_W-1:0];
        strict_mem[bus.cfg_ch] <= bus.cfg_data[TMO_W];
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] exp_sel;
    assign exp_sel = exp_mem[i][ptr_a[i][IDX_W-1:0]];

    checkpoint_channel #(
      .W     (W),
      .PTR_W (PTR_W),
      .TMO_W (TMO_W)
    ) u_ch (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .probe   (bus.probe),
      .arm     (bus.arm[i]),
      .start   (start_mem[i]),
      .exp_val (exp_sel),
      .len     (len_mem[i]),
      .limit   (limit_mem[i]),
      .strict  (strict_mem[i]),
      .hit     (hit[i]),
      .pass    (pass[i]),
      .fail    (fail[i]),
      .ptr     (ptr_a[i])
    );
  end

  always_comb begin
    ptr_flat = '0;
    for (int i = 0; i < CH; i++) ptr_flat[i*PTR_W +: PTR_W] = ptr_a[i];
  end

  assign bus.hit      = hit;
  assign bus.pass     = pass;
  assign bus.fail     = fail;
  assign bus.ptr      = ptr_flat;
  assign bus.all_done = all_done;

endmodule
